nzcv_cond_eval: RTL
===================

Name: nzcv_cond_eval

Overview:
- Consumer end of the ALU flag interface: captures the 4-bit NZCV produced by alu_nzcv, holds it in an architectural flags register, and answers condition-code queries for branch and conditional-execute logic.
- Sits between the ALU and the control/branch unit.
- Queries use a valid/ready handshake; results use a registered valid/ready response.
- Includes a small save/restore stack of flag words for exception entry and return.

Parameters:
- STACK_DEPTH, 4, number of saved NZCV entries (power of two, >= 2).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- i_flags_we  in  1  write i_nzcv into the flags register this cycle
- i_nzcv  in  4  {N,Z,C,V} from ALU
- i_cond_valid  in  1  condition query valid
- i_cond  in  4  condition code
- o_cond_ready  out  1  query accepted when valid and ready
- o_res_valid  out  1  result valid
- o_res_taken  out  1  condition holds
- i_res_ready  in  1  consumer accepts result
- i_push  in  1  save current flags to stack
- i_pop  in  1  restore flags from stack
- o_nzcv  out  4  architectural flags register
- o_stack_err  out  1  sticky overflow/underflow error

Behaviour:
- The interface is one clock (clk) with reset synchronous and active-high (reset). Both are fixed.
- Reset values:
  - o_nzcv = 4'b0000
  - o_res_valid = 0, o_res_taken = 0
  - stack pointer = 0, o_stack_err = 0
  - FSM = IDLE
  - o_cond_ready = 1 in the first cycle after reset.
- Reset mid-operation drops any pending result, clears the stack, and discards a same-cycle write.
- Flags register update priority (highest first):
  1. reset
  2. i_pop (flags = top-of-stack)
  3. i_flags_we (flags = i_nzcv)
  4. hold
- Simultaneous push and i_flags_we: the pushed value is the OLD flags, and the register takes i_nzcv.
- Simultaneous push and pop is illegal. The stack is unchanged and o_stack_err sets.
- Push when full, or pop when empty:
  - No state change to the stack or flags.
  - o_stack_err sets and stays set until reset.
- Condition decode, evaluated on the flags value F used for the query:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: 1
- FSM with two states, IDLE and RESP:
  - IDLE: o_cond_ready = 1. On i_cond_valid&&o_cond_ready, the result is registered and the FSM goes to RESP. o_res_valid is asserted the next cycle (latency 1).
  - RESP: o_res_valid = 1; o_res_taken is stable while valid.
    - i_res_ready=1 with no new query: go to IDLE.
    - i_res_ready=1 with a new query presented: o_cond_ready = i_res_ready, so a back-to-back query is accepted in the same cycle. Stay in RESP with the new result. Throughput is 1/cycle.
    - i_res_ready=0: o_cond_ready = 0 and the result is held.
- Flags hazard: a query accepted in the same cycle as i_flags_we or i_pop is governed by NZCV_FWD_EN.

Optional Feature:
- Macro: NZCV_FWD_EN.
- Defined: same-cycle forwarding.
  - A query accepted in a write/pop cycle evaluates the value being written (i_nzcv, or top-of-stack on pop).
  - o_cond_ready is not affected by writes.
- Undefined: o_cond_ready is forced 0 in any cycle with i_flags_we or i_pop.
  - The query stalls one cycle and is then evaluated on the updated register.
  - Queries never observe stale flags.

Test Plan:
1. Reset → o_nzcv=0000, o_res_valid=0, o_stack_err=0. Then i_flags_we with nzcv=0110 (result of 0-0 SUB), query EQ → next cycle o_res_valid=1, taken=1. Follow-up queries CS=1, HI=0, GE=1, GT=0.
2. Write nzcv=1000 (0+FFFFFFFF), query MI=1, PL=0, LT=1 (N≠V), LE=1. Then write 0010 (10000-1) and query HI=1, LS=0.
3. Backpressure: hold i_res_ready=0 for 3 cycles after an EQ query.
   - o_res_valid and o_res_taken stay stable.
   - o_cond_ready=0 throughout.
   - A second query (NE) waits and is answered the cycle after i_res_ready rises.
4. Stack:
   - Flags 0100, push; write 1000; pop → o_nzcv=0100.
   - Push 4 times (depth 4), then a 5th push → o_stack_err=1, stack unchanged.
   - Reset clears the error.
   - Pop on empty → err=1.
5. Hazard: with flags=0000, present an EQ query in the same cycle as i_flags_we with nzcv=0100.
   - With NZCV_FWD_EN: accepted that cycle, taken=1.
   - Without: o_cond_ready=0 that cycle, accepted next cycle, taken=1.
6. Reset asserted while in RESP with o_res_valid=1 → next cycle o_res_valid=0, o_nzcv=0000, FSM in IDLE.

Source files
------------

// File: rtl/nzcv_cond_eval.sv
// Architectural NZCV flags register, save/restore stack and condition evaluator.
// Optional same-cycle flag forwarding to queries: define NZCV_FWD_EN.
module nzcv_cond_eval #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_flags_we,
  input  logic [3:0] i_nzcv,
  input  logic       i_cond_valid,
  input  logic [3:0] i_cond,
  output logic       o_cond_ready,
  output logic       o_res_valid,
  output logic       o_res_taken,
  input  logic       i_res_ready,
  input  logic       i_push,
  input  logic       i_pop,
  output logic [3:0] o_nzcv,
  output logic       o_stack_err
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;

  logic [3:0]    r_nzcv;
  logic [3:0]    r_stack [STACK_DEPTH];
  logic [PW-1:0] r_sp;
  logic          r_err;
  logic [0:0]    r_state;
  logic          r_taken;

  logic          w_full;
  logic          w_empty;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_stk_err;
  logic [PW-1:0] w_sp_m1;
  logic [3:0]    w_top;
  logic [3:0]    w_nzcv_nxt;
  logic [3:0]    w_eval_f;
  logic          w_ready_base;
  logic          w_ready;
  logic          w_acc;
  logic          w_taken;

  function automatic logic f_eval(
    input logic [3:0] f,
    input logic [3:0] c
  );
    logic n, z, cf, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    unique case (c)
      4'h0:    r = z;
      4'h1:    r = !z;
      4'h2:    r = cf;
      4'h3:    r = !cf;
      4'h4:    r = n;
      4'h5:    r = !n;
      4'h6:    r = v;
      4'h7:    r = !v;
      4'h8:    r = cf & !z;
      4'h9:    r = !cf | z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = !z & (n == v);
      4'hD:    r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  assign w_full  = (r_sp == PW'(STACK_DEPTH));
  assign w_empty = (r_sp == '0);
  assign w_sp_m1 = r_sp - PW'(1);
  assign w_top   = r_stack[w_sp_m1[AW-1:0]];

  assign w_push_ok = i_push & !i_pop & !w_full;
  assign w_pop_ok  = i_pop & !i_push & !w_empty;
  // Any illegal stack op freezes both stack and flags for the cycle
  assign w_stk_err = (i_push & i_pop)
                   | (i_push & !i_pop & w_full)
                   | (i_pop & !i_push & w_empty);

  always_comb begin
    w_nzcv_nxt = r_nzcv;
    if (w_pop_ok)
      w_nzcv_nxt = w_top;
    else if (i_flags_we && !w_stk_err)
      w_nzcv_nxt = i_nzcv;
  end

  assign w_ready_base = (r_state == S_IDLE) | i_res_ready;

`ifdef NZCV_FWD_EN
  assign w_ready  = w_ready_base;
  assign w_eval_f = w_nzcv_nxt;
`else
  // Stall queries for one cycle whenever the flags may change
  assign w_ready  = w_ready_base & !(i_flags_we | i_pop);
  assign w_eval_f = r_nzcv;
`endif

  assign w_acc   = i_cond_valid & w_ready;
  assign w_taken = f_eval(w_eval_f, i_cond);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_nzcv <= 4'b0000;
      r_sp   <= '0;
      r_err  <= 1'b0;
    end else begin
      r_nzcv <= w_nzcv_nxt;
      if (w_stk_err)
        r_err <= 1'b1;
      if (w_push_ok)
        r_sp <= r_sp + PW'(1);
      else if (w_pop_ok)
        r_sp <= w_sp_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push_ok)
      r_stack[r_sp[AW-1:0]] <= r_nzcv;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_taken <= 1'b0;
    end else begin
      if (w_acc) begin
        r_state <= S_RESP;
        r_taken <= w_taken;
      end else if (r_state == S_RESP && i_res_ready) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign o_cond_ready = w_ready;
  assign o_res_valid  = (r_state == S_RESP);
  assign o_res_taken  = r_taken;
  assign o_nzcv       = r_nzcv;
  assign o_stack_err  = r_err;

endmodule
